change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: STOCK_INIT, 8, number of coins of each denomination (5, 2, 1 zl) loaded at reset and on refill; legal range 0..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request from the vending FSM to pay out change_in; sampled only in IDLE.
REQ-005 change_in  input  4  change owed in zl, 0..15; latched on an accepted start.
REQ-006 hopper_ready  input  1  coin mechanism ready for the next coin; level-sensitive.
REQ-007 refill  input  1  reload all three stocks to STOCK_INIT; honoured only in IDLE.
REQ-008 coin5, coin2, coin1  output  1 each  one-cycle eject pulse for the named coin; at most one high per cycle.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a payout finishes, successfully or not.
REQ-011 error  output  1  last payout could not be completed from stock.
REQ-012 shortfall  output  4  zl left unpaid by the last payout; 0 when error is 0.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SELECT, PULSE, WAIT and DONE.
REQ-014 IDLE: start=1 SHALL latch remaining=change_in, clear error and shortfall, and enter SELECT, including when change_in=0.
REQ-015 SELECT SHALL choose greedily, in this priority order:
  - remaining>=5 and stock5>0: coin 5
  - else remaining>=2 and stock2>0: coin 2
  - else remaining>=1 and stock1>0: coin 1
  - a coin chosen: register the choice and enter PULSE
REQ-016 SELECT with remaining=0 SHALL enter DONE with error=0.
REQ-017 SELECT with remaining>0 and no eligible coin SHALL set error=1 and shortfall=remaining, then enter DONE.
REQ-018 PULSE SHALL assert the chosen coin output for exactly one cycle.
REQ-019 PULSE SHALL subtract the coin value from remaining and decrement that coin's stock by 1, then enter WAIT.
REQ-020 WAIT SHALL stay while hopper_ready=0 and enter SELECT on the first cycle hopper_ready=1.
REQ-021 With hopper_ready held at 1, each coin SHALL take exactly 3 cycles (SELECT, PULSE, WAIT).
REQ-022 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-023 coin outputs and done SHALL be decoded from registered state only; no combinational path from inputs to outputs.
REQ-024 start while busy=1 SHALL be ignored and not queued; the in-flight payout is unaffected.
REQ-025 refill while busy=1 SHALL be ignored.
REQ-026 refill and start together in IDLE: the refill SHALL apply first, so the payout uses the reloaded stock.
REQ-027 Stock counters are 4-bit and SHALL never decrement below 0 (guaranteed by REQ-015).
REQ-028 remaining is 4-bit and SHALL never underflow.
REQ-029 error and shortfall SHALL hold their values until the next accepted start.

Reset
REQ-030 reset=1 SHALL force IDLE in the same edge, in any state, including mid-payout.
REQ-031 Reset values: coin5=coin2=coin1=0, busy=0, done=0, error=0, shortfall=0, remaining=0, each stock=STOCK_INIT.
REQ-032 reset SHALL take priority over start and refill.
REQ-033 A payout interrupted by reset SHALL not resume, and no done pulse SHALL be emitted for it.

Verification
REQ-034 Reset: hold reset for 2 cycles, then release -> all outputs 0, busy=0, and three payouts of 5 zl each succeed (stock5 is 8).
REQ-035 Tea-with-change case: hopper_ready=1; start pulse with change_in=3 at cycle 0 -> coin2 pulse at cycle 2, coin1 pulse at cycle 5, done at cycle 8, error=0, shortfall=0.
REQ-036 Payout 13: start with change_in=13 -> pulse sequence coin5, coin5, coin2, coin1, then done with error=0.
REQ-037 Stall: hopper_ready=0 for 10 cycles after the first coin pulse -> FSM holds in WAIT, busy=1, no extra pulses; the payout completes once hopper_ready=1.
REQ-038 Shortage, with STOCK_INIT=1:
  - payout of 1 zl -> succeeds
  - then payout of 3 zl -> coin2 pulse, then done with error=1, shortfall=1
REQ-039 Reset mid-payout and ignored start:
  - reset asserted during WAIT -> busy=0 next cycle, no done pulse
  - start pulse while busy -> ignored, no additional coins
  - change_in=0 -> done pulses 2 cycles after start, no coin pulses

Source files
------------

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays out an amount using greedy 5/2/1 zl selection
// from finite stocks, one coin at a time paced by the hopper handshake.
module change_dispenser #(
  parameter int STOCK_INIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] change_in,
  input  logic       hopper_ready,
  input  logic       refill,
  output logic       coin5,
  output logic       coin2,
  output logic       coin1,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] shortfall,
  output logic [2:0] dbg_state
);

  // Handshake: start/refill are only looked at in IDLE; each coin is one
  // PULSE cycle, and the FSM waits in WAIT until hopper_ready is seen high.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_5    = 2'd1,
    C_2    = 2'd2,
    C_1    = 2'd3
  } coin_t;

  localparam logic [3:0] INIT = 4'(STOCK_INIT);

  state_t     state, next_state;
  coin_t      chosen, pick;
  logic [3:0] remaining;
  logic [3:0] stock5, stock2, stock1;

  // Greedy choice: largest coin that fits and is still in stock.
  always_comb begin
    pick = C_NONE;
    if (remaining >= 4'd5 && stock5 != 4'd0)      pick = C_5;
    else if (remaining >= 4'd2 && stock2 != 4'd0) pick = C_2;
    else if (remaining >= 4'd1 && stock1 != 4'd0) pick = C_1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_SELECT;
      S_SELECT: begin
        if (remaining != 4'd0 && pick != C_NONE) next_state = S_PULSE;
        else                                     next_state = S_DONE;
      end
      S_PULSE:  next_state = S_WAIT;
      S_WAIT:   if (hopper_ready) next_state = S_SELECT;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= 4'd0;
      stock5    <= INIT;
      stock2    <= INIT;
      stock1    <= INIT;
      chosen    <= C_NONE;
      error     <= 1'b0;
      shortfall <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // Refill lands first so a simultaneous start sees the full stock.
          if (refill) begin
            stock5 <= INIT;
            stock2 <= INIT;
            stock1 <= INIT;
          end
          if (start) begin
            remaining <= change_in;
            error     <= 1'b0;
            shortfall <= 4'd0;
          end
        end
        S_SELECT: begin
          if (remaining != 4'd0) begin
            if (pick != C_NONE) begin
              chosen <= pick;
            end else begin
              error     <= 1'b1;
              shortfall <= remaining;
            end
          end
        end
        S_PULSE: begin
          case (chosen)
            C_5: begin
              remaining <= remaining - 4'd5;
              stock5    <= stock5 - 4'd1;
            end
            C_2: begin
              remaining <= remaining - 4'd2;
              stock2    <= stock2 - 4'd1;
            end
            C_1: begin
              remaining <= remaining - 4'd1;
              stock1    <= stock1 - 4'd1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    coin5     = (state == S_PULSE) && (chosen == C_5);
    coin2     = (state == S_PULSE) && (chosen == C_2);
    coin1     = (state == S_PULSE) && (chosen == C_1);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    dbg_state = state;
  end

endmodule
